// File: rtl/fifo_wr_packer.sv
// Byte-lane packer feeding the async FIFO write port (write clock domain).
// Define WR_PACK_LAST_EN to let i_last close a partial word early.
module fifo_wr_packer #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_valid,
  input  logic [IN_WIDTH-1:0]           i_data,
  input  logic                          i_last,
  output logic                          o_ready,
  input  logic                          i_full_flag,
  output logic                          o_wr_en,
  output logic [IN_WIDTH*RATIO-1:0]     o_wr_data,
  output logic [$clog2(RATIO):0]        o_wr_lanes
);

  localparam int W  = IN_WIDTH * RATIO;
  localparam int CW = $clog2(RATIO);
  localparam int LW = CW + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(RATIO - 1);

  logic [W-1:0]  asm_q;
  logic [W-1:0]  asm_nxt;
  logic [CW-1:0] cnt_q;
  logic          pending_q;
  logic          accept;
  logic          close_word;
  logic          complete;

  assign o_ready = !i_rst && (!pending_q || !i_full_flag);
  assign o_wr_en = !i_rst && pending_q && !i_full_flag;
  assign accept  = i_valid && o_ready;

`ifdef WR_PACK_LAST_EN
  assign close_word = (cnt_q == CNT_MAX) || i_last;
`else
  logic unused_last;
  assign unused_last = i_last;
  assign close_word  = (cnt_q == CNT_MAX);
`endif

  assign complete = accept && close_word;

  // Upper lanes of asm_q are always zero, so partial words come out zero-padded.
  always_comb begin
    asm_nxt = asm_q;
    asm_nxt[cnt_q*IN_WIDTH +: IN_WIDTH] = i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      asm_q      <= '0;
      cnt_q      <= '0;
      pending_q  <= 1'b0;
      o_wr_data  <= '0;
      o_wr_lanes <= '0;
    end else begin
      if (complete) begin
        o_wr_data  <= asm_nxt;
        o_wr_lanes <= LW'(cnt_q) + LW'(1);
        asm_q      <= '0;
        cnt_q      <= '0;
      end else if (accept) begin
        asm_q <= asm_nxt;
        cnt_q <= cnt_q + CW'(1);
      end
      // A completion in the same cycle as a write refills the output slot.
      if (complete)
        pending_q <= 1'b1;
      else if (o_wr_en)
        pending_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Directed + random bench for fifo_wr_packer against a lane-queue model.
module tb_fifo_wr_packer;

  localparam int IW = 8;
  localparam int R  = 4;
  localparam int LW = $clog2(R) + 1;
`ifdef WR_PACK_LAST_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_valid = 1'b0;
  logic [IW-1:0] i_data = '0;
  logic          i_last = 1'b0;
  logic          i_full_flag = 1'b0;
  logic          o_ready;
  logic          o_wr_en;
  logic [IW*R-1:0] o_wr_data;
  logic [LW-1:0] o_wr_lanes;

  always #5 i_clk = ~i_clk;

  fifo_wr_packer #(.IN_WIDTH(IW), .RATIO(R)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
    .i_last(i_last), .o_ready(o_ready), .i_full_flag(i_full_flag),
    .o_wr_en(o_wr_en), .o_wr_data(o_wr_data), .o_wr_lanes(o_wr_lanes)
  );

  typedef struct {
    logic [31:0] d;
    int          n;
  } word_t;

  int tests = 0;
  int fails = 0;
  logic [IW-1:0] acc[$];
  word_t exp_q[$];
  logic [31:0] hold_d = '0;
  int hold_n = 0;
  int cyc = 0;
  int dut_wr = 0;
  logic [31:0] dut_last = '0;
  int dut_last_n = 0;
  int wr_cyc[$];
  bit last_er = 1'b1;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step(bit v, logic [IW-1:0] d, bit l, bit f, bit r);
    bit er;
    bit ew;
    word_t w;
    @(negedge i_clk);
    i_valid = v; i_data = d; i_last = l; i_full_flag = f; i_rst = r;
    #1;
    cyc++;
    er = !r && (exp_q.size() == 0 || !f);
    ew = !r && exp_q.size() != 0 && !f;
    last_er = er;
    check("ready", 32'(o_ready), 32'(er));
    check("wr_en", 32'(o_wr_en), 32'(ew));
    if (exp_q.size() != 0) begin
      check("wr_data", o_wr_data, exp_q[0].d);
      check("wr_lanes", 32'(o_wr_lanes), 32'(exp_q[0].n));
    end else begin
      check("held_data", o_wr_data, hold_d);
      check("held_lanes", 32'(o_wr_lanes), 32'(hold_n));
    end
    if (o_wr_en === 1'b1) begin
      dut_wr++;
      dut_last = o_wr_data;
      dut_last_n = int'(o_wr_lanes);
      wr_cyc.push_back(cyc);
    end
    if (r) begin
      acc.delete();
      exp_q.delete();
      hold_d = '0;
      hold_n = 0;
    end else begin
      if (ew) begin
        w = exp_q.pop_front();
        hold_d = w.d;
        hold_n = w.n;
      end
      if (v && er) begin
        acc.push_back(d);
        if (acc.size() == R || (LAST_EN && l)) begin
          w.d = '0;
          foreach (acc[i]) w.d[i*IW +: IW] = acc[i];
          w.n = acc.size();
          exp_q.push_back(w);
          acc.delete();
        end
      end
    end
  endtask

  initial begin
    int base;
    bit v, l, f, r;
    logic [IW-1:0] d;

    repeat (2) @(posedge i_clk);
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 0);

    // single word, one-cycle latency
    base = dut_wr;
    step(1, 8'h11, 0, 0, 0);
    step(1, 8'h22, 0, 0, 0);
    step(1, 8'h33, 0, 0, 0);
    step(1, 8'h44, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    check("s1_word", dut_last, 32'h44332211);
    check("s1_lanes", 32'(dut_last_n), 32'd4);
    check("s1_count", 32'(dut_wr - base), 32'd1);

    // back-to-back words
    base = dut_wr;
    wr_cyc.delete();
    for (int i = 1; i <= 8; i++) step(1, IW'(i), 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    check("s2_count", 32'(dut_wr - base), 32'd2);
    check("s2_word", dut_last, 32'h08070605);
    if (wr_cyc.size() == 2)
      check("s2_gap", 32'(wr_cyc[1] - wr_cyc[0]), 32'd4);

    // full while pending
    base = dut_wr;
    step(1, 8'hAA, 0, 0, 0);
    step(1, 8'hBB, 0, 0, 0);
    step(1, 8'hCC, 0, 0, 0);
    step(1, 8'hDD, 0, 0, 0);
    repeat (5) step(0, 8'h00, 0, 1, 0);
    check("s3_blocked", 32'(dut_wr - base), 32'd0);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    check("s3_count", 32'(dut_wr - base), 32'd1);
    check("s3_word", dut_last, 32'hDDCCBBAA);

    // i_last
    base = dut_wr;
    step(1, 8'hA1, 0, 0, 0);
    step(1, 8'hA2, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
`ifdef WR_PACK_LAST_EN
    check("s4_count", 32'(dut_wr - base), 32'd1);
    check("s4_word", dut_last, 32'h0000A2A1);
    check("s4_lanes", 32'(dut_last_n), 32'd2);
    for (int i = 0; i < 4; i++) step(1, IW'(8'hB0 + i), 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    check("s4_full", dut_last, 32'hB3B2B1B0);
`else
    check("s4_count", 32'(dut_wr - base), 32'd0);
    step(1, 8'hB0, 0, 0, 0);
    step(1, 8'hB1, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    check("s4_word", dut_last, 32'hB1B0A2A1);
    check("s4_lanes", 32'(dut_last_n), 32'd4);
`endif

    // reset mid-word
    step(1, 8'hE1, 0, 0, 0);
    step(1, 8'hE2, 0, 0, 0);
    step(1, 8'hE3, 0, 0, 0);
    base = dut_wr;
    step(0, 8'h00, 0, 0, 1);
    step(1, 8'h55, 0, 0, 0);
    step(1, 8'h66, 0, 0, 0);
    step(1, 8'h77, 0, 0, 0);
    step(1, 8'h88, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    check("s5_count", 32'(dut_wr - base), 32'd1);
    check("s5_word", dut_last, 32'h88776655);

    // lane held during full is not lost
    for (int i = 1; i <= 4; i++) step(1, IW'(8'hC0 + i), 0, 0, 0);
    repeat (3) step(1, 8'h99, 0, 1, 0);
    step(1, 8'h99, 0, 0, 0);
    step(1, 8'h9A, 0, 0, 0);
    step(1, 8'h9B, 0, 0, 0);
    step(1, 8'h9C, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    check("s6_word", dut_last, 32'h9C9B9A99);

    // random traffic; stalled lanes are held by the source
    v = 0; d = '0; l = 0;
    for (int i = 0; i < 600; i++) begin
      if (!(v && !last_er)) begin
        v = ($urandom_range(0, 9) < 7);
        d = IW'($urandom);
        l = ($urandom_range(0, 9) < 2);
      end
      f = ($urandom_range(0, 9) < 3);
      r = ($urandom_range(0, 59) == 0);
      step(v, d, l, f, r);
      if (r) v = 0;
    end
    repeat (3) step(0, 8'h00, 0, 0, 0);
    check("rand_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
